// File: rtl/alog_share_sched.sv
// alog_share_sched
//   Time-shares one combinational Q3.12 antilog converter among NREQ
//   requesters in the log-domain FLAF weight/update path. A start pulse arms
//   a frame mask. Each armed requester is granted once, in round-robin
//   order. Results pass through a 2-stage pipeline that honours output
//   backpressure. A done pulse marks the point where the frame is fully
//   drained.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   start            one-cycle frame start (ignored while busy)
//   frame_mask       requesters to serve, sampled on an accepted start
//   busy, done       frame in progress / one-cycle end-of-frame pulse
//   req_valid        per-requester valid
//   req_ready        one-hot grant
//   req_data         packed signed Q3.12 log magnitudes, 18 bits each
//   req_sign         linear value is negative
//   req_zero         linear value is exactly zero
//   alog_data        converter input (stage-1 log value)
//   alog_adata       converter result (15-bit magnitude)
//   resp_valid/ready response handshake
//   resp_id          served requester index
//   resp_data        signed 16-bit linear result
module alog_share_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NREQ-1:0]      frame_mask,
  output logic                 busy,
  output logic                 done,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*18-1:0]   req_data,
  input  logic [NREQ-1:0]      req_sign,
  input  logic [NREQ-1:0]      req_zero,
  output logic [17:0]          alog_data,
  input  logic [14:0]          alog_adata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          resp_data
);

  localparam int DATA_W = 18;
  localparam int OUT_W  = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [NREQ-1:0]           pending, pending_nxt, elig;
  logic [IDW-1:0]            ptr, gnt_id;
  logic                      gnt, advance, done_nxt;
  logic signed [DATA_W-1:0]  gnt_data;
  logic                      gnt_sign, gnt_zero;

  logic                      s1_valid;
  logic [IDW-1:0]            s1_id;
  logic signed [DATA_W-1:0]  s1_data;
  logic                      s1_sign, s1_zero;

  // Sign/zero application. The magnitude is at most 15 bits, so negation
  // cannot overflow 16 bits. Negative zero collapses to 0 naturally.
  function automatic logic signed [OUT_W-1:0] to_linear(
    input logic [14:0] adata,
    input logic        sgn,
    input logic        zro
  );
    logic signed [OUT_W-1:0] mag;
    mag = signed'({1'b0, adata});
    if (zro)      return '0;
    else if (sgn) return -mag;
    else          return mag;
  endfunction

  assign advance   = !resp_valid || resp_ready;
  assign busy      = (state != IDLE);
  assign alog_data = s1_data;

  // Round-robin pick. First search indices above ptr, then wrap to those
  // at or below it.
  always_comb begin
    gnt    = 1'b0;
    gnt_id = '0;
    elig   = pending & req_valid;
    if (state == RUN && advance) begin
      for (int i = 0; i < NREQ; i++)
        if (!gnt && elig[i] && IDW'(i) > ptr) begin
          gnt    = 1'b1;
          gnt_id = IDW'(i);
        end
      for (int i = 0; i < NREQ; i++)
        if (!gnt && elig[i] && IDW'(i) <= ptr) begin
          gnt    = 1'b1;
          gnt_id = IDW'(i);
        end
    end
  end

  always_comb begin
    req_ready = '0;
    gnt_data  = '0;
    gnt_sign  = 1'b0;
    gnt_zero  = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (gnt && gnt_id == IDW'(i)) begin
        req_ready[i] = 1'b1;
        gnt_data     = signed'(req_data[DATA_W*i +: DATA_W]);
        gnt_sign     = req_sign[i];
        gnt_zero     = req_zero[i];
      end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending & ~req_ready;
    done_nxt    = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          pending_nxt = frame_mask;
          state_nxt   = (frame_mask == '0) ? DRAIN : RUN;
        end
      RUN:
        if (pending_nxt == '0) state_nxt = DRAIN;
      DRAIN:
        if (!s1_valid && !resp_valid) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      ptr        <= IDW'(NREQ - 1);
      done       <= 1'b0;
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_data    <= '0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      done    <= done_nxt;
      if (gnt) ptr <= gnt_id;
      if (advance) begin
        // grant -> stage 1
        s1_valid   <= gnt;
        s1_id      <= gnt_id;
        s1_data    <= gnt_data;
        s1_sign    <= gnt_sign;
        s1_zero    <= gnt_zero;
        // stage 1 + converter -> output
        resp_valid <= s1_valid;
        resp_id    <= s1_id;
        resp_data  <= to_linear(alog_adata, s1_sign, s1_zero);
      end
    end
  end

endmodule

// File: tb/tb_alog_share_sched.sv
// tb_alog_share_sched
//   Directed bench for alog_share_sched. It includes a behavioural
//   piecewise-linear antilog converter: mantissa 1+f, shifted by the integer
//   exponent, with zero returned outside +2..-12.
module tb_alog_share_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst, start, busy, done, resp_valid, resp_ready;
  logic [NREQ-1:0]   frame_mask, req_valid, req_ready, req_sign, req_zero;
  logic [NREQ*18-1:0] req_data;
  logic [17:0]       alog_data;
  logic [14:0]       alog_adata;
  logic [IDW-1:0]    resp_id;
  logic [15:0]       resp_data;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alog_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_mask(frame_mask),
    .busy(busy), .done(done), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_sign(req_sign), .req_zero(req_zero),
    .alog_data(alog_data), .alog_adata(alog_adata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data)
  );

  logic signed [17:0] cv_x;
  int cv_e, cv_m;
  always_comb begin
    cv_x = alog_data;
    cv_e = int'(cv_x >>> 12);
    cv_m = 4096 + int'(alog_data[11:0]);
    if (cv_e > 2 || cv_e < -12) alog_adata = '0;
    else if (cv_e >= 0)         alog_adata = 15'(cv_m << cv_e);
    else                        alog_adata = 15'(cv_m >> (-cv_e));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [17:0] d, input logic s, input logic z);
    req_data[18*i +: 18] = d;
    req_sign[i] = s;
    req_zero[i] = z;
  endtask

  task automatic wait_resp(input string tag, input int exp_id, input logic [15:0] exp_data);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        got = 1;
        check({tag, "_id"}, resp_id, exp_id);
        check({tag, "_data"}, resp_data, exp_data);
      end
      tick();
    end
    check({tag, "_resp_seen"}, got, 1);
  endtask

  task automatic wait_done(input string tag);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      tick();
    end
    check({tag, "_done_seen"}, got, 1);
  endtask

  task automatic single(input string tag, input logic [17:0] d, input logic s,
                        input logic z, input logic [15:0] exp);
    set_req(0, d, s, z);
    req_valid = 4'b0001; start = 1'b1; frame_mask = 4'b0001;
    tick();
    start = 1'b0; frame_mask = '0;
    wait_resp(tag, 0, exp);
    wait_done(tag);
  endtask

  logic [15:0] t3_exp [4] = '{16'h1000, 16'h2000, 16'h4000, 16'hF800};

  initial begin
    int ng, nd, nr, bad, nrv;
    int gord [2];
    int rids [4];
    logic [15:0] rdat [4];

    rst = 1'b1; start = 1'b0; frame_mask = '0; req_valid = '1;
    req_data = '0; req_sign = '0; req_zero = '0; resp_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rv", resp_valid, 0);
    check("rst_id", resp_id, 0);
    check("rst_data", resp_data, 0);
    check("rst_alog", alog_data, 0);
    tick();
    rst = 1'b0; req_valid = '0;

    // single request with exact timing
    set_req(0, 18'h01000, 1'b0, 1'b0);
    req_valid = 4'b0001; start = 1'b1; frame_mask = 4'b0001;
    @(negedge clk); check("t1_idle_ready", req_ready, 0);
    tick(); start = 1'b0; frame_mask = '0;
    @(negedge clk); check("t1_hs", req_ready, 4'b0001); check("t1_busy", busy, 1);
    tick();
    @(negedge clk); check("t1_s1", alog_data, 18'h01000); check("t1_norv", resp_valid, 0);
    tick();
    @(negedge clk); check("t1_rv", resp_valid, 1); check("t1_id", resp_id, 0);
    check("t1_data", resp_data, 16'h2000);
    tick();
    @(negedge clk); check("t1_nodone", done, 0); check("t1_rv_off", resp_valid, 0);
    tick();
    @(negedge clk); check("t1_done", done, 1); check("t1_busy_off", busy, 0);
    tick();
    @(negedge clk); check("t1_done_pulse", done, 0);
    tick();

    // sign, zero and underflow handling
    single("t2_neg",   18'h00800, 1'b1, 1'b0, 16'hE800);
    single("t2_zero",  18'h00800, 1'b1, 1'b1, 16'h0000);
    single("t2_uflow", 18'h33000, 1'b0, 1'b0, 16'h0000);

    // round-robin fairness from reset pointer
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 18'h00000, 1'b0, 1'b0);
    set_req(1, 18'h01000, 1'b0, 1'b0);
    set_req(2, 18'h02000, 1'b0, 1'b0);
    set_req(3, 18'h3F000, 1'b1, 1'b0);
    req_valid = 4'hF; start = 1'b1; frame_mask = 4'hF;
    tick(); start = 1'b0; frame_mask = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t3_gnt", req_ready, (c < 4) ? (1 << c) : 0);
      check("t3_rv", resp_valid, (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        check("t3_id", resp_id, c - 2);
        check("t3_data", resp_data, t3_exp[c-2]);
      end
      tick();
    end
    wait_done("t3_f1");
    start = 1'b1; frame_mask = 4'hF;
    tick(); start = 1'b0; frame_mask = '0;
    @(negedge clk); check("t3_wrap", req_ready, 4'b0001);
    tick();
    for (int k = 0; k < 4; k++) wait_resp("t3_f2", k, t3_exp[k]);
    wait_done("t3_f2");

    // partial mask, late requester
    req_valid = 4'b1101; start = 1'b1; frame_mask = 4'b1010;
    tick(); start = 1'b0; frame_mask = '0;
    ng = 0; nd = 0; nr = 0; bad = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 5) req_valid = 4'hF;
      @(negedge clk);
      if ((req_ready & 4'b0101) != 0) bad++;
      if (req_ready != 0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i] && ng < 2) gord[ng] = i;
        ng++;
      end
      if (done) nd++;
      if (resp_valid && resp_ready && nr < 4) begin
        rids[nr] = int'(resp_id); rdat[nr] = resp_data; nr++;
      end
      tick();
    end
    check("t4_masked", bad, 0);
    check("t4_ngrants", ng, 2);
    check("t4_first", gord[0], 3);
    check("t4_second", gord[1], 1);
    check("t4_ndone", nd, 1);
    check("t4_nresp", nr, 2);
    check("t4_rid0", rids[0], 3);
    check("t4_rdat0", rdat[0], 16'hF800);
    check("t4_rid1", rids[1], 1);
    check("t4_rdat1", rdat[1], 16'h2000);

    // backpressure with two results in flight
    set_req(0, 18'h3F800, 1'b0, 1'b0);
    req_valid = 4'hF; start = 1'b1; frame_mask = 4'b0111;
    tick(); start = 1'b0; frame_mask = '0;
    @(negedge clk); check("t5_g0", req_ready, 4'b0100); tick();
    @(negedge clk); check("t5_g1", req_ready, 4'b0001); tick();
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_stall_rv", resp_valid, 1);
      check("t5_stall_id", resp_id, 2);
      check("t5_stall_data", resp_data, 16'h4000);
      check("t5_stall_ready", req_ready, 0);
      check("t5_stall_s1", alog_data, 18'h3F800);
      tick();
    end
    resp_ready = 1'b1;
    nr = 0; nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        if (nr < 4) begin rids[nr] = int'(resp_id); rdat[nr] = resp_data; end
        nr++;
      end
      if (done) nd++;
      tick();
    end
    check("t5_nresp", nr, 3);
    check("t5_rid0", rids[0], 2);
    check("t5_rdat0", rdat[0], 16'h4000);
    check("t5_rid1", rids[1], 0);
    check("t5_rdat1", rdat[1], 16'h0C00);
    check("t5_rid2", rids[2], 1);
    check("t5_rdat2", rdat[2], 16'h2000);
    check("t5_ndone", nd, 1);

    // empty frame
    start = 1'b1; frame_mask = '0;
    tick(); start = 1'b0;
    @(negedge clk); check("t6_empty_busy", busy, 1); check("t6_empty_nodone", done, 0);
    tick();
    @(negedge clk); check("t6_empty_done", done, 1); check("t6_empty_idle", busy, 0);
    tick();

    // start while busy is ignored
    req_valid = '0; start = 1'b1; frame_mask = 4'b0001;
    tick();
    start = 1'b1; frame_mask = 4'b1110; req_valid = 4'hF;
    @(negedge clk); check("t6_busy_gnt", req_ready, 4'b0001);
    tick(); start = 1'b0; frame_mask = '0;
    @(negedge clk); check("t6_ignored", req_ready, 0);
    tick();
    wait_resp("t6b", 0, 16'h0C00);
    wait_done("t6b");

    // reset mid-frame
    start = 1'b1; frame_mask = 4'hF; req_valid = 4'hF;
    tick(); start = 1'b0; frame_mask = '0;
    tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_rv", resp_valid, 0);
    check("t6_rst_id", resp_id, 0);
    check("t6_rst_data", resp_data, 0);
    check("t6_rst_alog", alog_data, 0);
    check("t6_rst_done", done, 0);
    tick();
    nd = 0; nrv = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (resp_valid) nrv++;
      tick();
    end
    check("t6_rst_nodone", nd, 0);
    check("t6_rst_norv", nrv, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
